nexus_rv16: RTL and testbench

- 16-bit, 3-stage pipelined RISC CPU: IF, ID, EX. EX performs ALU, memory access and register writeback.
- Contains 16 x 16-bit GPRs, 4 flags, SP, and a unified internal word memory.
- The memory has a host port used to load programs and inspect data. Execution starts at 0x0100.

---
 rtl/nexus_rv16.sv | 197 +++++++++++++++++++
 tb/tb_nexus_rv16.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nexus_rv16.sv
// nexus_rv16: 3-stage (IF, ID, EX) 16-bit RISC core with a unified word memory and a host port.
// Define NEXUS_MUL_EN to make opcode D a 16x16 multiply (low half); otherwise D is a NOP.
module nexus_rv16 #(
  parameter int          MEM_AW   = 12,
  parameter logic [15:0] RESET_PC = 16'h0100,
  parameter logic [15:0] RESET_SP = 16'h1FFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_in,
  input  logic [15:0] ext_addr,
  input  logic [15:0] ext_data_in,
  input  logic        ext_write_en,
  output logic [15:0] ext_data_out,
  output logic [15:0] test_pc,
  output logic [15:0] test_sp,
  output logic [15:0] test_ar,
  output logic [15:0] test_dr,
  output logic [15:0] test_ir,
  output logic [3:0]  test_flags
);
  localparam logic [15:0] NOP = 16'hFFFF;

  logic [15:0] mem [0:(1<<MEM_AW)-1];
  logic [15:0] regs [0:15];
  logic [15:0] pc, sp, ar, dr;
  logic [3:0]  flags;  // {Z,N,C,V}
  logic        halted, run;

  logic [15:0] ir_p1, pc_p1;
  logic        vld_p1;
  logic [15:0] ir_p2, pc_p2, a_p2, b_p2;
  logic        vld_p2;

  logic [3:0]         op_p2, ra_p2, wa;
  logic signed [15:0] imm_p2;
  logic [15:0]        res, mem_addr, mem_rdata, sp_nxt, dr_nxt, ra_id, rb_id, fetch_ir;
  logic [3:0]         flags_nxt;
  logic [19:0]        as_out;
  logic               reg_we, flags_we, mem_we, mem_acc, br_taken, hlt, logic_op;
  logic               unused_addr;

  // Returns {Z,N,C,V,result}; for subtraction C is the borrow.
  function automatic logic [19:0] add_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic sub);
    logic [16:0] u;
    logic        v;
    if (sub) begin
      u = {1'b0, x} - {1'b0, y};
      v = (x[15] != y[15]) && (u[15] != x[15]);
    end else begin
      u = {1'b0, x} + {1'b0, y};
      v = (x[15] == y[15]) && (u[15] != x[15]);
    end
    return {u[15:0] == 16'h0, u[15], u[16], v, u[15:0]};
  endfunction

  assign run          = !sel_in && !halted;
  assign fetch_ir     = mem[pc[MEM_AW:1]];
  assign mem_rdata    = mem[mem_addr[MEM_AW:1]];
  assign ext_data_out = mem[ext_addr[MEM_AW:1]];
  assign unused_addr  = ^{ext_addr[15:MEM_AW+1], ext_addr[0]};

  assign test_pc    = pc;
  assign test_sp    = sp;
  assign test_ar    = ar;
  assign test_dr    = dr;
  assign test_ir    = ir_p2;
  assign test_flags = flags;

  // ---- ID: register read, write-through from EX ----
  always_comb begin
    ra_id = regs[ir_p1[11:8]];
    rb_id = regs[ir_p1[7:4]];
    if (reg_we && wa == ir_p1[11:8]) ra_id = res;
    if (reg_we && wa == ir_p1[7:4])  rb_id = res;
  end

  // ---- EX: ALU, memory access, writeback, branch resolution ----
  assign op_p2  = ir_p2[15:12];
  assign ra_p2  = ir_p2[11:8];
  assign imm_p2 = {{8{ir_p2[7]}}, ir_p2[7:0]};
  assign as_out = add_sub(a_p2, b_p2, op_p2[0]);

  always_comb begin
    res       = 16'h0;
    wa        = ir_p2[3:0];
    reg_we    = 1'b0;
    flags_nxt = flags;
    flags_we  = 1'b0;
    logic_op  = 1'b0;
    mem_addr  = {8'h00, ir_p2[7:0]};
    mem_we    = 1'b0;
    mem_acc   = 1'b0;
    dr_nxt    = a_p2;
    sp_nxt    = sp;
    br_taken  = 1'b0;
    hlt       = 1'b0;
    if (vld_p2) begin
      case (op_p2)
        4'h0, 4'h1: begin
          res = as_out[15:0]; flags_nxt = as_out[19:16]; reg_we = 1'b1; flags_we = 1'b1;
        end
        4'h2: begin res = a_p2 & b_p2;        logic_op = 1'b1; end
        4'h3: begin res = a_p2 | b_p2;        logic_op = 1'b1; end
        4'h4: begin res = a_p2 ^ b_p2;        logic_op = 1'b1; end
        4'h5: begin res = ~a_p2;              logic_op = 1'b1; end
        4'h6: begin res = a_p2 << b_p2[3:0];  logic_op = 1'b1; end
        4'h7: begin res = a_p2 >> b_p2[3:0];  logic_op = 1'b1; end
        4'h8: begin
          sp_nxt = sp - 16'd2; mem_addr = sp - 16'd2; mem_we = 1'b1; mem_acc = 1'b1;
        end
        4'h9: begin
          mem_addr = sp; sp_nxt = sp + 16'd2; mem_acc = 1'b1; dr_nxt = mem_rdata;
          res = mem_rdata; wa = ra_p2; reg_we = 1'b1;
        end
        4'hA: begin res = imm_p2; wa = ra_p2; reg_we = 1'b1; end
        4'hB: begin
          mem_acc = 1'b1; dr_nxt = mem_rdata; res = mem_rdata; wa = ra_p2; reg_we = 1'b1;
        end
        4'hC: begin mem_we = 1'b1; mem_acc = 1'b1; end
`ifdef NEXUS_MUL_EN
        4'hD: begin res = a_p2 * b_p2; logic_op = 1'b1; end
`endif
        4'hE: br_taken = (ra_p2 == 4'h0) || (ra_p2 == 4'h4 && flags[3]) ||
                         (ra_p2 == 4'h8 && !flags[3]);
        4'hF: hlt = (ra_p2 == 4'hE);
        default: ;
      endcase
      if (logic_op) begin
        reg_we    = 1'b1;
        flags_we  = 1'b1;
        flags_nxt = {res == 16'h0, res[15], 2'b00};
      end
    end
  end

  // Single write port: the host owns it whenever the core is stalled by sel_in.
  always_ff @(posedge clk) begin
    if (sel_in) begin
      if (ext_write_en) mem[ext_addr[MEM_AW:1]] <= ext_data_in;
    end else if (run && mem_we) begin
      mem[mem_addr[MEM_AW:1]] <= a_p2;
    end
  end

  // ---- pipeline registers: IF -> p1 (IF/ID) -> p2 (ID/EX) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      sp     <= RESET_SP;
      ar     <= 16'h0;
      dr     <= 16'h0;
      flags  <= 4'h0;
      halted <= 1'b0;
      ir_p1  <= NOP;
      pc_p1  <= 16'h0;
      vld_p1 <= 1'b0;
      ir_p2  <= NOP;
      pc_p2  <= 16'h0;
      a_p2   <= 16'h0;
      b_p2   <= 16'h0;
      vld_p2 <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0;
    end else if (run) begin
      if (reg_we)   regs[wa] <= res;
      if (flags_we) flags <= flags_nxt;
      if (mem_acc) begin
        ar <= mem_addr;
        dr <= dr_nxt;
      end
      sp <= sp_nxt;
      if (hlt) begin
        // HLT stays in EX so test_ir keeps showing it until reset.
        halted <= 1'b1;
        ir_p1  <= NOP;
        vld_p1 <= 1'b0;
      end else if (br_taken) begin
        pc     <= pc_p2 + imm_p2;
        ir_p1  <= NOP;
        vld_p1 <= 1'b0;
        ir_p2  <= NOP;
        vld_p2 <= 1'b0;
      end else begin
        pc     <= pc + 16'd2;
        ir_p1  <= fetch_ir;
        pc_p1  <= pc;
        vld_p1 <= 1'b1;
        ir_p2  <= ir_p1;
        pc_p2  <= pc_p1;
        a_p2   <= ra_id;
        b_p2   <= rb_id;
        vld_p2 <= vld_p1;
      end
    end
  end
endmodule

// File: tb/tb_nexus_rv16.sv
// Bench for nexus_rv16: host-loaded programs, expected state from an instruction-level interpreter.
`timescale 1ns/1ps
module tb_nexus_rv16;
  logic        clk = 1'b0, rst = 1'b0, sel_in = 1'b1, ext_write_en = 1'b0;
  logic [15:0] ext_addr = 16'h0, ext_data_in = 16'h0;
  logic [15:0] ext_data_out, test_pc, test_sp, test_ar, test_dr, test_ir;
  logic [3:0]  test_flags;

  nexus_rv16 dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .ext_addr(ext_addr), .ext_data_in(ext_data_in),
    .ext_write_en(ext_write_en), .ext_data_out(ext_data_out), .test_pc(test_pc),
    .test_sp(test_sp), .test_ar(test_ar), .test_dr(test_dr), .test_ir(test_ir),
    .test_flags(test_flags)
  );

  always #5 clk = ~clk;

  typedef enum int {K_MEM, K_SP, K_AR, K_DR, K_FLAGS, K_IR, K_PC} kind_t;
  typedef struct {
    kind_t       kind;
    logic [15:0] addr;
    logic [15:0] val;
  } chk_t;

  chk_t        sb[$];
  logic        probe = 1'b0;
  int          vectors = 0, miscompares = 0;
  logic [15:0] shadow [0:4095];
  logic [15:0] m_reg [0:15];
  logic [15:0] m_sp, m_ar, m_dr;
  logic [3:0]  m_flags;
  logic [15:0] prog [$];

  // Monitor: pops one expectation for every cycle the stimulus presents a probe.
  initial begin
    chk_t        c;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (probe) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_underflow got probe want queued entry");
        end else begin
          c = sb.pop_front();
          case (c.kind)
            K_MEM:   act = ext_data_out;
            K_SP:    act = test_sp;
            K_AR:    act = test_ar;
            K_DR:    act = test_dr;
            K_FLAGS: act = {12'h0, test_flags};
            K_IR:    act = test_ir;
            default: act = test_pc;
          endcase
          vectors++;
          if (act !== c.val) begin
            miscompares++;
            $display("FAIL %s addr=%h got %h want %h", c.kind.name(), c.addr, act, c.val);
          end
        end
      end
    end
  end

  task automatic issue(input kind_t k, input logic [15:0] addr, input logic [15:0] val);
    chk_t c;
    c.kind = k; c.addr = addr; c.val = val;
    ext_addr = addr;
    sb.push_back(c);
    probe = 1'b1;
    @(posedge clk); #2;
    probe = 1'b0;
  endtask

  task automatic host_write(input logic [15:0] addr, input logic [15:0] data);
    ext_addr = addr; ext_data_in = data; ext_write_en = 1'b1;
    shadow[addr[12:1]] = data;
    @(posedge clk); #2;
    ext_write_en = 1'b0;
  endtask

  // Instruction-by-instruction interpreter over the shadow memory; no pipeline notion.
  task automatic model_run();
    logic [15:0] pc, ir, a, b, r, imm;
    logic [3:0]  op, fa;
    int          sa, sbv, sr;
    bit          done, lg;
    done = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    pc = 16'h0100; m_sp = 16'h1FFE; m_ar = 16'h0; m_dr = 16'h0; m_flags = 4'h0;
    for (int step = 0; step < 2000 && !done; step++) begin
      ir  = shadow[pc[12:1]];
      op  = ir[15:12]; fa = ir[11:8];
      a   = m_reg[fa]; b = m_reg[ir[7:4]];
      imm = {{8{ir[7]}}, ir[7:0]};
      sa  = int'($signed(a)); sbv = int'($signed(b));
      lg  = 0; r = 16'h0;
      case (op)
        4'h0, 4'h1: begin
          if (op == 4'h0) begin
            r = a + b; sr = sa + sbv; m_flags[1] = (int'(a) + int'(b)) > 65535;
          end else begin
            r = a - b; sr = sa - sbv; m_flags[1] = a < b;
          end
          m_flags[3] = (r == 0); m_flags[2] = r[15];
          m_flags[0] = (sr > 32767) || (sr < -32768);
          m_reg[ir[3:0]] = r;
        end
        4'h2: begin r = a & b; lg = 1; end
        4'h3: begin r = a | b; lg = 1; end
        4'h4: begin r = a ^ b; lg = 1; end
        4'h5: begin r = 16'hFFFF - a; lg = 1; end
        4'h6: begin r = 16'(longint'(a) * (longint'(1) << b[3:0])); lg = 1; end
        4'h7: begin r = 16'(int'(a) / (1 << b[3:0])); lg = 1; end
        4'h8: begin m_sp = m_sp - 16'd2; shadow[m_sp[12:1]] = a; m_ar = m_sp; m_dr = a; end
        4'h9: begin
          r = shadow[m_sp[12:1]]; m_reg[fa] = r; m_ar = m_sp; m_dr = r; m_sp = m_sp + 16'd2;
        end
        4'hA: m_reg[fa] = imm;
        4'hB: begin m_ar = {8'h0, ir[7:0]}; m_dr = shadow[m_ar[12:1]]; m_reg[fa] = m_dr; end
        4'hC: begin m_ar = {8'h0, ir[7:0]}; shadow[m_ar[12:1]] = a; m_dr = a; end
`ifdef NEXUS_MUL_EN
        4'hD: begin r = 16'(longint'(a) * longint'(b)); lg = 1; end
`endif
        4'hE: if (fa == 4'h0 || (fa == 4'h4 && m_flags[3]) || (fa == 4'h8 && !m_flags[3]))
                pc = pc + imm - 16'd2;
        4'hF: if (fa == 4'hE) done = 1;
        default: ;
      endcase
      if (lg) begin
        m_reg[ir[3:0]] = r;
        m_flags = {r == 16'h0, r[15], 2'b00};
      end
      if (!done) pc = pc + 16'd2;
    end
  endtask

  task automatic append_dump();
    for (int i = 0; i < 16; i++) prog.push_back({4'hC, 4'(i), 8'(8'h60 + 2 * i)});
    prog.push_back(16'hFE00);
  endtask

  task automatic make_random();
    logic [3:0] op, fa;
    prog.delete();
    for (int i = 0; i < 24; i++) begin
      op = (i < 4) ? 4'hA : 4'($urandom_range(0, 15));
      if (op == 4'hE) begin
        case ($urandom_range(0, 3))
          0: fa = 4'h0;
          1: fa = 4'h4;
          2: fa = 4'h8;
          default: fa = 4'($urandom_range(0, 15));
        endcase
        prog.push_back({4'hE, fa, 8'(2 * $urandom_range(1, 4))});
      end else if (op == 4'hF) begin
        prog.push_back({4'hF, 4'($urandom_range(0, 13)), 8'($urandom)});
      end else begin
        prog.push_back({op, 12'($urandom)});
      end
    end
    append_dump();
  endtask

  task automatic run_prog(input int freeze_k);
    int n;
    sel_in = 1'b1;
    for (int i = 0; i < prog.size(); i++) host_write(16'(16'h0100 + 2 * i), prog[i]);
    model_run();
    rst = 1'b1; #1;
    issue(K_PC, 16'h0, 16'h0100);
    issue(K_SP, 16'h0, 16'h1FFE);
    issue(K_FLAGS, 16'h0, 16'h0);
    issue(K_IR, 16'h0, 16'hFFFF);
    issue(K_AR, 16'h0, 16'h0);
    rst = 1'b0; sel_in = 1'b0;
    if (freeze_k >= 2) begin
      repeat (freeze_k) begin @(posedge clk); #2; end
      sel_in = 1'b1;
      repeat (3) begin @(posedge clk); #2; end
      issue(K_PC, 16'h0, 16'(16'h0100 + 2 * freeze_k));
      issue(K_IR, 16'h0, prog[freeze_k - 2]);
      sel_in = 1'b0;
    end
    n = 0;
    while (test_ir !== 16'hFE00 && n < 3000) begin @(posedge clk); #2; n++; end
    repeat (2) begin @(posedge clk); #2; end
    issue(K_IR, 16'h0, 16'hFE00);
    issue(K_SP, 16'h0, m_sp);
    issue(K_AR, 16'h0, m_ar);
    issue(K_DR, 16'h0, m_dr);
    issue(K_FLAGS, 16'h0, {12'h0, m_flags});
    for (int a = 0; a < 256; a += 2) issue(K_MEM, 16'(a), shadow[a / 2]);
    for (int a = 16'h1FC0; a < 16'h2000; a += 2) issue(K_MEM, 16'(a), shadow[a / 2]);
    sel_in = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 4096; i++) host_write(16'(2 * i), 16'h0);

    prog = '{16'hA00A, 16'hA105, 16'h0012, 16'h1013};                    append_dump(); run_prog(3);
    prog = '{16'hA0FF, 16'hA10F, 16'h2012, 16'h3013, 16'h4014};           append_dump(); run_prog(4);
    prog = '{16'hA001, 16'hA104, 16'h6012, 16'hA380, 16'h7314};           append_dump(); run_prog(0);
    prog = '{16'hA0AB, 16'hC050, 16'hFFFF, 16'hFFFF, 16'hB150, 16'hFFFF, 16'hFFFF};
    append_dump(); run_prog(0);
    prog = '{16'hA000, 16'hA100, 16'h1012, 16'hE404, 16'hA399, 16'hA444}; append_dump(); run_prog(0);
    prog = '{16'hA555, 16'hE004, 16'hA6EE, 16'hA777};                     append_dump(); run_prog(0);
    prog = '{16'hA005, 16'hA103, 16'h1012, 16'hE804, 16'hA333, 16'hA411}; append_dump(); run_prog(0);
    prog = '{16'hA0AB, 16'h8000, 16'h9200};                               append_dump(); run_prog(0);
    for (int t = 0; t < 20; t++) begin make_random(); run_prog(0); end

    // Asynchronous reset while running, after a SUB has set Z.
    sel_in = 1'b1;
    prog = '{16'hA0FF, 16'hA1FF, 16'h1012};
    for (int i = 0; i < 10; i++) prog.push_back(16'hFFFF);
    prog.push_back(16'hFE00);
    for (int i = 0; i < prog.size(); i++) host_write(16'(16'h0100 + 2 * i), prog[i]);
    rst = 1'b1; @(posedge clk); #2; rst = 1'b0; sel_in = 1'b0;
    repeat (8) begin @(posedge clk); #2; end
    rst = 1'b1;
    issue(K_PC, 16'h0, 16'h0100);
    issue(K_FLAGS, 16'h0, 16'h0);
    rst = 1'b0; sel_in = 1'b1;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
